ram_1p_arbiter: RTL and testbench

//  Shares one single-port SRAM between the Ibex instruction-fetch and data ports.

---
 rtl/ram_1p_arbiter.sv | 133 +++++++++++++
 tb/tb_ram_1p_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_1p_arbiter.sv
// Arbitrates the Ibex instruction-fetch and data ports onto one single-port RAM with a
// 1-cycle read latency, bounding data streaks so fetch cannot starve.
module ram_1p_arbiter #(
    parameter int unsigned Depth         = 16384,
    parameter logic [31:0] MemStart      = 32'h0000_0000,
    parameter int unsigned MaxDataStreak = 4,
    localparam int unsigned AW           = $clog2(Depth),
    localparam int unsigned SW           = $clog2(MaxDataStreak + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,

    input  logic          instr_req_i,
    input  logic [31:0]   instr_addr_i,
    output logic          instr_gnt_o,
    output logic          instr_rvalid_o,
    output logic [31:0]   instr_rdata_o,
    output logic          instr_err_o,

    input  logic          data_req_i,
    input  logic          data_we_i,
    input  logic [3:0]    data_be_i,
    input  logic [31:0]   data_addr_i,
    input  logic [31:0]   data_wdata_i,
    output logic          data_gnt_o,
    output logic          data_rvalid_o,
    output logic [31:0]   data_rdata_o,
    output logic          data_err_o,

    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [3:0]    mem_be_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [31:0]   mem_wdata_o,
    input  logic [31:0]   mem_rdata_i
);

    localparam logic [SW-1:0] StreakMax = SW'(MaxDataStreak);
    localparam logic [33:0]   WinBytes  = 34'(Depth) << 2;

    logic [SW-1:0] streak_q, streak_d;
    logic          resp_vld_q;
    logic          resp_own_q;
    logic          resp_err_q;
    logic          resp_we_q;

    logic          instr_win;
    logic          data_win;
    logic          grant_any;
    logic [31:0]   sel_addr;
    logic [31:0]   sel_off;
    logic          in_range;

    // Data has priority until it has been granted StreakMax times in a row over a waiting fetch.
    always_comb begin
        instr_win = 1'b0;
        data_win  = 1'b0;
        if (!rst_i) begin
            if (instr_req_i && data_req_i) begin
                instr_win = (streak_q == StreakMax);
                data_win  = !instr_win;
            end else begin
                instr_win = instr_req_i;
                data_win  = data_req_i;
            end
        end
    end

    assign instr_gnt_o = instr_win;
    assign data_gnt_o  = data_win;
    assign grant_any   = instr_win | data_win;

    assign sel_addr = instr_win ? instr_addr_i : data_addr_i;
    assign sel_off  = sel_addr - MemStart;
    assign in_range = ({2'b00, sel_off} < WinBytes);

    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'h0;
        mem_addr_o  = '0;
        mem_wdata_o = 32'h0;
        if (grant_any && in_range) begin
            mem_req_o  = 1'b1;
            mem_addr_o = sel_off[AW+1:2];
            if (data_win) begin
                mem_we_o    = data_we_i;
                mem_be_o    = data_be_i;
                mem_wdata_o = data_wdata_i;
            end else begin
                mem_be_o = 4'hF;
            end
        end
    end

    always_comb begin
        streak_d = streak_q;
        if (!instr_req_i || instr_win) begin
            streak_d = '0;
        end else if (data_win && (streak_q != StreakMax)) begin
            streak_d = streak_q + SW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resp_vld_q <= 1'b0;
            resp_own_q <= 1'b0;
            resp_err_q <= 1'b0;
            resp_we_q  <= 1'b0;
            streak_q   <= '0;
        end else begin
            resp_vld_q <= grant_any;
            if (grant_any) begin
                resp_own_q <= data_win;
                resp_err_q <= !in_range;
                resp_we_q  <= data_win & data_we_i;
            end
            streak_q <= streak_d;
        end
    end

    // Responses are suppressed while reset is held so an in-flight grant is dropped.
    always_comb begin
        instr_rvalid_o = resp_vld_q && !resp_own_q && !rst_i;
        data_rvalid_o  = resp_vld_q && resp_own_q && !rst_i;
        instr_err_o    = instr_rvalid_o && resp_err_q;
        data_err_o     = data_rvalid_o && resp_err_q;
        instr_rdata_o  = (instr_rvalid_o && !resp_err_q) ? mem_rdata_i : 32'h0;
        data_rdata_o   = (data_rvalid_o && !resp_err_q && !resp_we_q) ? mem_rdata_i : 32'h0;
    end

endmodule

// File: tb/tb_ram_1p_arbiter.sv
// Bench for ram_1p_arbiter: directed vectors, a behavioural RAM, and a per-cycle reference model.
module tb_ram_1p_arbiter;

    localparam int unsigned Depth     = 16384;
    localparam logic [31:0] MemStart  = 32'h0000_0000;
    localparam int unsigned MaxStreak = 4;
    localparam int unsigned AW        = $clog2(Depth);

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          instr_req_i = 1'b0;
    logic [31:0]   instr_addr_i = 32'h0;
    logic          instr_gnt_o, instr_rvalid_o, instr_err_o;
    logic [31:0]   instr_rdata_o;
    logic          data_req_i = 1'b0, data_we_i = 1'b0;
    logic [3:0]    data_be_i = 4'h0;
    logic [31:0]   data_addr_i = 32'h0, data_wdata_i = 32'h0;
    logic          data_gnt_o, data_rvalid_o, data_err_o;
    logic [31:0]   data_rdata_o;
    logic          mem_req_o, mem_we_o;
    logic [3:0]    mem_be_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_wdata_o;
    logic [31:0]   mem_rdata_i = 32'h0;

    int errors = 0;
    int checks = 0;

    ram_1p_arbiter #(
        .Depth(Depth), .MemStart(MemStart), .MaxDataStreak(MaxStreak)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
        .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
        .instr_err_o(instr_err_o),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
        .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Behavioural single-port RAM driven by the DUT.
    logic [31:0] ram [Depth];
    always @(posedge clk_i) begin
        if (mem_req_o) begin
            if (mem_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be_o[b]) ram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
            end else begin
                mem_rdata_i <= ram[mem_addr_o];
            end
        end
    end

    // Reference model: expected memory contents, one pending response, and a streak counter.
    logic [31:0] shadow [Depth];
    int          m_streak = 0;
    logic        pend_v = 1'b0, pend_data = 1'b0, pend_err = 1'b0;
    logic [31:0] pend_rdata = 32'h0;
    logic        e_ig, e_dg, e_inr, e_we;
    logic [31:0] e_addr, e_off;
    int          e_word;

    always @(negedge clk_i) begin
        if (rst_i) begin
            chk("rst_instr_gnt", 32'(instr_gnt_o), 32'h0);
            chk("rst_data_gnt", 32'(data_gnt_o), 32'h0);
            chk("rst_mem_req", 32'(mem_req_o), 32'h0);
            chk("rst_instr_rvalid", 32'(instr_rvalid_o), 32'h0);
            chk("rst_data_rvalid", 32'(data_rvalid_o), 32'h0);
            m_streak = 0;
            pend_v   = 1'b0;
        end else begin
            chk("instr_rvalid", 32'(instr_rvalid_o), 32'(pend_v && !pend_data));
            chk("data_rvalid", 32'(data_rvalid_o), 32'(pend_v && pend_data));
            chk("instr_err", 32'(instr_err_o), 32'(pend_v && !pend_data && pend_err));
            chk("data_err", 32'(data_err_o), 32'(pend_v && pend_data && pend_err));
            chk("instr_rdata", instr_rdata_o, (pend_v && !pend_data) ? pend_rdata : 32'h0);
            chk("data_rdata", data_rdata_o, (pend_v && pend_data) ? pend_rdata : 32'h0);

            if (instr_req_i && data_req_i) begin
                e_dg = (m_streak < MaxStreak);
                e_ig = !e_dg;
            end else begin
                e_ig = instr_req_i;
                e_dg = data_req_i;
            end
            chk("instr_gnt", 32'(instr_gnt_o), 32'(e_ig));
            chk("data_gnt", 32'(data_gnt_o), 32'(e_dg));

            if (e_ig || e_dg) begin
                e_addr = e_ig ? instr_addr_i : data_addr_i;
                e_off  = e_addr - MemStart;
                e_inr  = (64'(e_off) < 64'(Depth) * 64'd4);
                e_word = int'(e_off / 4);
                e_we   = e_dg && data_we_i;
                chk("mem_req", 32'(mem_req_o), 32'(e_inr));
                if (e_inr) begin
                    chk("mem_we", 32'(mem_we_o), 32'(e_we));
                    chk("mem_be", 32'(mem_be_o), e_dg ? 32'(data_be_i) : 32'hF);
                    chk("mem_addr", 32'(mem_addr_o), 32'(e_word));
                    if (e_dg) chk("mem_wdata", mem_wdata_o, data_wdata_i);
                end
                pend_v     = 1'b1;
                pend_data  = e_dg;
                pend_err   = !e_inr;
                pend_rdata = (!e_inr || e_we) ? 32'h0 : shadow[e_word];
                if (e_inr && e_we)
                    for (int b = 0; b < 4; b++)
                        if (data_be_i[b]) shadow[e_word][8*b +: 8] = data_wdata_i[8*b +: 8];
            end else begin
                chk("idle_mem_req", 32'(mem_req_o), 32'h0);
                chk("idle_mem_we", 32'(mem_we_o), 32'h0);
                chk("idle_mem_be", 32'(mem_be_o), 32'h0);
                chk("idle_mem_addr", 32'(mem_addr_o), 32'h0);
                chk("idle_mem_wdata", mem_wdata_o, 32'h0);
                pend_v = 1'b0;
            end

            if (!instr_req_i || e_ig) m_streak = 0;
            else if (e_dg && m_streak < MaxStreak) m_streak++;
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        instr_req_i = 1'b0;
        data_req_i  = 1'b0;
        data_we_i   = 1'b0;
        data_be_i   = 4'h0;
        data_wdata_i = 32'h0;
    endtask

    task automatic drive_d(input logic we, input logic [3:0] be, input logic [31:0] addr,
                           input logic [31:0] wdata);
        data_req_i   = 1'b1;
        data_we_i    = we;
        data_be_i    = be;
        data_addr_i  = addr;
        data_wdata_i = wdata;
    endtask

    typedef struct {
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [3:0]  dbe;
        logic [31:0] daddr;
        logic [31:0] dwdata;
    } vec_t;
    vec_t vecs[8];

    logic [11:0] pat;

    initial begin
        for (int i = 0; i < int'(Depth); i++) begin
            ram[i]    = 32'h0;
            shadow[i] = 32'h0;
        end
        ram[32'h20]    = 32'hDEAD_BEEF;
        shadow[32'h20] = 32'hDEAD_BEEF;

        repeat (3) step();
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("lit_reset_instr_rvalid", 32'(instr_rvalid_o), 32'h0);
        chk("lit_reset_data_err", 32'(data_err_o), 32'h0);
        step();

        // Fetch read
        instr_req_i = 1'b1; instr_addr_i = 32'h80;
        @(negedge clk_i);
        chk("lit_t1_gnt", 32'(instr_gnt_o), 32'h1);
        chk("lit_t1_mem_addr", 32'(mem_addr_o), 32'h20);
        step(); idle();
        @(negedge clk_i);
        chk("lit_t1_rvalid", 32'(instr_rvalid_o), 32'h1);
        chk("lit_t1_rdata", instr_rdata_o, 32'hDEAD_BEEF);
        chk("lit_t1_err", 32'(instr_err_o), 32'h0);
        step();

        // Data byte write
        drive_d(1'b1, 4'b0001, 32'hC010, 32'h5);
        @(negedge clk_i);
        chk("lit_t2_we", 32'(mem_we_o), 32'h1);
        chk("lit_t2_be", 32'(mem_be_o), 32'h1);
        chk("lit_t2_addr", 32'(mem_addr_o), 32'h3004);
        step(); idle();
        @(negedge clk_i);
        chk("lit_t2_rvalid", 32'(data_rvalid_o), 32'h1);
        chk("lit_t2_rdata", data_rdata_o, 32'h0);
        step();

        // Contention: D,D,D,D,I repeating
        pat = 12'b1101_1110_1111;
        instr_req_i = 1'b1; instr_addr_i = 32'h100;
        drive_d(1'b0, 4'hF, 32'h200, 32'h0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_i);
            chk("lit_t3_data_gnt", 32'(data_gnt_o), 32'(pat[i]));
            chk("lit_t3_instr_gnt", 32'(instr_gnt_o), 32'(!pat[i]));
            step();
        end
        idle();
        step();

        // Out-of-range data access
        drive_d(1'b0, 4'hF, 32'h0001_0000, 32'h0);
        @(negedge clk_i);
        chk("lit_t4_gnt", 32'(data_gnt_o), 32'h1);
        chk("lit_t4_mem_req", 32'(mem_req_o), 32'h0);
        step(); idle();
        @(negedge clk_i);
        chk("lit_t4_rvalid", 32'(data_rvalid_o), 32'h1);
        chk("lit_t4_err", 32'(data_err_o), 32'h1);
        chk("lit_t4_rdata", data_rdata_o, 32'h0);
        step();

        // Alternating owners back to back
        instr_req_i = 1'b1; instr_addr_i = 32'h84;
        step();
        instr_req_i = 1'b0; drive_d(1'b0, 4'hF, 32'hC010, 32'h0);
        @(negedge clk_i);
        chk("lit_t5a_irv", 32'(instr_rvalid_o), 32'h1);
        chk("lit_t5a_drv", 32'(data_rvalid_o), 32'h0);
        step();
        idle(); instr_req_i = 1'b1; instr_addr_i = 32'h80;
        @(negedge clk_i);
        chk("lit_t5b_drv", 32'(data_rvalid_o), 32'h1);
        chk("lit_t5b_irv", 32'(instr_rvalid_o), 32'h0);
        chk("lit_t5b_rdata", data_rdata_o, 32'h5);
        step();
        instr_req_i = 1'b0; drive_d(1'b0, 4'hF, 32'hC010, 32'h0);
        @(negedge clk_i);
        chk("lit_t5c_irv", 32'(instr_rvalid_o), 32'h1);
        chk("lit_t5c_rdata", instr_rdata_o, 32'hDEAD_BEEF);
        step(); idle();
        @(negedge clk_i);
        chk("lit_t5d_drv", 32'(data_rvalid_o), 32'h1);
        step();

        // Reset right after a fetch grant drops the response
        instr_req_i = 1'b1; instr_addr_i = 32'h80;
        step();
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("lit_t6_gnt", 32'(instr_gnt_o), 32'h0);
        chk("lit_t6_rvalid_in_rst", 32'(instr_rvalid_o), 32'h0);
        step();
        rst_i = 1'b0; idle();
        @(negedge clk_i);
        chk("lit_t6_rvalid", 32'(instr_rvalid_o), 32'h0);
        chk("lit_t6_err", 32'(instr_err_o), 32'h0);
        chk("lit_t6_streak", 32'(dut.streak_q), 32'h0);
        step();

        // Boundary and mixed vectors, checked by the model
        vecs[0] = '{1'b0, 32'h0,         1'b1, 1'b1, 4'hF,    32'h0000_FFFC, 32'hA5A5_1234};
        vecs[1] = '{1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 4'hF,    32'h0000_FFFC, 32'h0};
        vecs[2] = '{1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 4'h0,    32'h0,         32'h0};
        vecs[3] = '{1'b0, 32'h0,         1'b1, 1'b1, 4'b0110, 32'h0000_0040, 32'h1122_3344};
        vecs[4] = '{1'b1, 32'h0000_0040, 1'b1, 1'b0, 4'hF,    32'h0000_FFFC, 32'h0};
        vecs[5] = '{1'b1, 32'h0000_0042, 1'b0, 1'b0, 4'h0,    32'h0,         32'h0};
        vecs[6] = '{1'b0, 32'h0,         1'b1, 1'b0, 4'hF,    32'h0001_0003, 32'h0};
        vecs[7] = '{1'b0, 32'h0,         1'b0, 1'b0, 4'h0,    32'h0,         32'h0};
        foreach (vecs[i]) begin
            instr_req_i  = vecs[i].ireq;
            instr_addr_i = vecs[i].iaddr;
            data_req_i   = vecs[i].dreq;
            data_we_i    = vecs[i].dwe;
            data_be_i    = vecs[i].dbe;
            data_addr_i  = vecs[i].daddr;
            data_wdata_i = vecs[i].dwdata;
            step();
        end
        idle();
        repeat (2) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
